vram_slot_sequencer: RTL and testbench
======================================

# vram_slot_sequencer

Time-slot sequencer and CPU arbiter for the shared 4K×16 video RAM. It generates the 3-bit `VRAC` slot code that steers the VRAM address mux (playfield, motion-object, alphanumerics, CPU). It grants the 68k one access window per 8-clock character cell, drives the VRAM read/write/bus-direction strobes, and returns an active-low DTACK. It sits between the address decoder / 68k bus interface and the video RAM datapath, replacing the fixed VRAC timing from the clock generator.

## Interface
Parameters:
- none (slot map fixed; see Operation)

Ports:
- `clk`  in  1  master pixel clock (MCKR rate); all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU VRAM access request from address decoder; held until `dtack_b` low
- `cpu_we`  in  1  1 = write, 0 = read; valid while `cpu_req` high
- `hblank`  in  1  horizontal blank, synchronous to `clk` (used only with macro)
- `VRAC`  out  3  {write-phase, slot[1:0]} to VRAM address mux
- `VRAMWR`  out  1  VRAM write strobe, active high
- `VRAMRD_b`  out  1  CPU read path enable, active low
- `VBUS_b`  out  1  68k↔VBD buffer enable, active low
- `BR_W_b`  out  1  buffer direction: 0 = CPU→VRAM (write), 1 = read
- `vbd_le`  out  1  one-clock pulse: read data valid on VBD, latch now
- `dtack_b`  out  1  access complete, active low
- `phase`  out  3  free-running cell phase, for debug/alignment

## Operation
- Phase counter `ph[2:0]` increments every clock, wraps 7→0. Slot `s = ph[2:1]`: 0 playfield, 1 MO, 2 alpha, 3 CPU.
- `VRAC = {ph[0], VRAC_slot}`. `VRAC_slot = s`, except a granted borrowed slot (Configuration), which shows 2'b11.
- Arbiter FSM states:
  - IDLE
    - → GRANT on the edge where `ph` becomes 6 if `cpu_req`=1
    - → WAIT if `cpu_req`=1 otherwise
  - WAIT
    - → GRANT on the edge `ph` 5→6 if `cpu_req`=1
    - → IDLE if `cpu_req`=0 (aborted, no VRAM cycle)
  - GRANT
    - lasts exactly `ph`=6,7; `cpu_we` captured into `we_q` on entry
    - edge 7→0: → DONE if `cpu_req`=1, else → IDLE
  - DONE
    - `dtack_b`=0; → IDLE on first clock `cpu_req`=0
    - a new request must not begin until `cpu_req` has been low ≥1 clock
- Outputs in GRANT:
  - `VBUS_b`=0
  - `BR_W_b`=~`we_q`
  - `VRAMRD_b`=`we_q`
  - `VRAMWR`=`we_q` & (`ph`=7)
  - `vbd_le`=~`we_q` & (`ph`=7)
- Outside GRANT all strobes are inactive: `VRAMWR`=0, `VRAMRD_b`=1, `VBUS_b`=1, `BR_W_b`=1, `vbd_le`=0.
- CPU slot with no grant: `VRAC`=3'b?11 still emitted; `VRAMWR` stays 0 (video reads unaffected).
- `cpu_we` change during GRANT is ignored (`we_q` used).

## Timing
- Reset (async, `rst`=0):
  - `ph`=0, FSM=IDLE
  - `VRAC`=3'b000
  - `VRAMWR`=0, `VRAMRD_b`=1, `VBUS_b`=1, `BR_W_b`=1, `vbd_le`=0, `dtack_b`=1
- Reset mid-GRANT kills the strobes immediately (combinational from state), with no write completion.
- Release: first edge after `rst` rises gives `ph`=1.
- All outputs are registered or decoded from registered state only. `VRAMWR` is glitch-free: it is a single-clock high at `ph`=7.
- Latency from `cpu_req` rise to `dtack_b` low: min 2 clocks (req seen at edge into `ph`=6), max 10 clocks (req rises just after the 5→6 edge).
- `dtack_b` is asserted from the edge `ph` 7→0 until the edge after `cpu_req` falls.

## Configuration
- `VRAM_HBLANK_CPU_EN` defined:
  - While `hblank`=1, slot 1 (MO, `ph` 2,3) is an additional CPU window.
  - Grant is also taken on the edge `ph` 1→2 when `cpu_req`=1 and FSM in IDLE/WAIT.
  - `VRAC[1:0]`=2'b11 during the borrowed slot; strobes follow the GRANT rules at `ph` 2,3.
  - DONE entered on edge 3→4.
  - `hblank` is sampled at the grant edge only; a fall mid-GRANT does not truncate the access.
- Not defined: `hblank` ignored; the CPU window is slot 3 only; max latency 10 clocks.

## Test plan
- Reset release, no requests: `VRAC` cycles 000,100,001,101,010,110,011,111 repeatedly; `VRAMWR` never 1; `dtack_b`=1.
- Write request asserted at `ph`=2 with `cpu_we`=1: at `ph`=6,7 `VBUS_b`=0, `BR_W_b`=0; `VRAMWR`=1 only at `ph`=7; `dtack_b`=0 from next `ph`=0; deassert req → `dtack_b`=1 one clock later.
- Read request rising just after the 5→6 edge: waits 8 clocks; next `ph`=7 gives `vbd_le`=1, `VRAMRD_b`=0; total latency 10 clocks to `dtack_b`=0.
- Request raised at `ph`=3 and dropped at `ph`=5: no GRANT; all strobes inactive; `dtack_b` stays 1.
- `rst` asserted at `ph`=6 of a write grant: `VRAMWR` remains 0, all outputs at reset values immediately; after release the FSM is IDLE with `ph`=0→1.
- With `VRAM_HBLANK_CPU_EN`, `hblank`=1, req at `ph`=0: grant at `ph`=2, `VRAC`=011/111 at `ph`=2/3; `dtack_b`=0 at `ph`=4. Same stimulus with `hblank`=0: grant at `ph`=6.

Source files
------------

// File: rtl/vram_slot_sequencer.sv
// VRAM time-slot sequencer and 68k access arbiter: one CPU window per 8-clock cell.
// Optional macro VRAM_HBLANK_CPU_EN lends the MO slot to the CPU during hblank.
module vram_slot_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       hblank,
  output logic [2:0] VRAC,
  output logic       VRAMWR,
  output logic       VRAMRD_b,
  output logic       VBUS_b,
  output logic       BR_W_b,
  output logic       vbd_le,
  output logic       dtack_b,
  output logic [2:0] phase
);

  // state | meaning
  // IDLE  | no CPU access pending
  // WAIT  | request seen, waiting for the next CPU window
  // GRANT | two-clock VRAM access window owned by the CPU
  // DONE  | access finished, dtack_b low until cpu_req drops
  typedef enum logic [1:0] {IDLE, WAIT, GRANT, DONE} state_t;

  state_t     state;
  logic [2:0] ph;
  logic       we_q;
  logic       borrow;
  logic       main_edge;
  logic       borrow_edge;
  logic       grant;

  assign main_edge = (ph == 3'd5);

`ifdef VRAM_HBLANK_CPU_EN
  assign borrow_edge = (ph == 3'd1) && hblank;
`else
  logic unused_hblank;
  assign unused_hblank = hblank;
  assign borrow_edge   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph     <= 3'd0;
      state  <= IDLE;
      we_q   <= 1'b0;
      borrow <= 1'b0;
    end else begin
      ph <= ph + 3'd1;
      case (state)
        IDLE, WAIT: begin
          if (cpu_req && (main_edge || borrow_edge)) begin
            state  <= GRANT;
            we_q   <= cpu_we;
            borrow <= borrow_edge;
          end else if (cpu_req) begin
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        // windows always start on an even phase, so odd phase is the last clock
        GRANT: if (ph[0]) state <= cpu_req ? DONE : IDLE;
        DONE:  if (!cpu_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // strobes decode from registered state so an async reset clears them at once
  assign grant    = (state == GRANT);
  assign VRAC     = {ph[0], (grant && borrow) ? 2'b11 : ph[2:1]};
  assign VBUS_b   = ~grant;
  assign BR_W_b   = ~(grant & we_q);
  assign VRAMRD_b = ~(grant & ~we_q);
  assign VRAMWR   = grant & we_q & ph[0];
  assign vbd_le   = grant & ~we_q & ph[0];
  assign dtack_b  = ~(state == DONE);
  assign phase    = ph;

endmodule

// File: tb/tb_vram_slot_sequencer.sv
// Self-checking bench for vram_slot_sequencer: directed steps plus random traffic
// compared against a window/acknowledge model of the CPU access protocol.
module tb_vram_slot_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic       hblank = 1'b0;
  logic [2:0] VRAC;
  logic       VRAMWR;
  logic       VRAMRD_b;
  logic       VBUS_b;
  logic       BR_W_b;
  logic       vbd_le;
  logic       dtack_b;
  logic [2:0] phase;

  vram_slot_sequencer dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .hblank(hblank),
    .VRAC(VRAC), .VRAMWR(VRAMWR), .VRAMRD_b(VRAMRD_b), .VBUS_b(VBUS_b),
    .BR_W_b(BR_W_b), .vbd_le(vbd_le), .dtack_b(dtack_b), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: cell position, clocks left in the CPU window, and acknowledge flag
  int ph_m = 0;
  int win_left = 0;
  bit acked = 1'b0;
  bit m_we = 1'b0;
  bit m_borrow = 1'b0;
`ifdef VRAM_HBLANK_CPU_EN
  bit hb_en = 1'b1;
`else
  bit hb_en = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph_m = 0; win_left = 0; acked = 1'b0; m_we = 1'b0; m_borrow = 1'b0;
  endtask

  task automatic model_update(input logic r, input logic w, input logic h);
    if (acked) begin
      if (!r) acked = 1'b0;
    end else if (win_left > 0) begin
      win_left--;
      if (win_left == 0) acked = r;
    end else if (r && (ph_m == 5 || (hb_en && h && ph_m == 1))) begin
      win_left = 2;
      m_we = w;
      m_borrow = (ph_m == 1);
    end
    ph_m = (ph_m + 1) % 8;
  endtask

  task automatic check_outputs();
    bit ing, last;
    int slot;
    ing  = (win_left > 0);
    last = (win_left == 1);
    slot = (ing && m_borrow) ? 3 : ph_m / 2;
    chk("phase",    {5'b0, phase},    8'(ph_m));
    chk("vrac",     {5'b0, VRAC},     8'((ph_m % 2) * 4 + slot));
    chk("vramwr",   {7'b0, VRAMWR},   {7'b0, ing && m_we && last});
    chk("vramrd_b", {7'b0, VRAMRD_b}, {7'b0, !(ing && !m_we)});
    chk("vbus_b",   {7'b0, VBUS_b},   {7'b0, !ing});
    chk("br_w_b",   {7'b0, BR_W_b},   {7'b0, !(ing && m_we)});
    chk("vbd_le",   {7'b0, vbd_le},   {7'b0, ing && !m_we && last});
    chk("dtack_b",  {7'b0, dtack_b},  {7'b0, !acked});
  endtask

  // called at a negedge: drive inputs, advance model, sample after the next edge
  task automatic step(input logic r, input logic w, input logic h);
    cpu_req = r; cpu_we = w; hblank = h;
    model_update(r, w, h);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_until(input int target);
    for (int i = 0; i < 8 && ph_m != target; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lat;
    int dph;
    logic r, w, h;

    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("release_phase", {5'b0, phase}, 8'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0);

    // write request raised at ph=2, held until acknowledged, then dropped
    idle_until(2);
    for (int i = 0; i < 12 && !acked; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // read request rising just after the 5->6 edge: worst-case latency
    idle_until(6);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      lat++;
      if (dtack_b == 1'b0) break;
    end
    chk("read_latency", 8'(lat), 8'd10);
    step(1'b0, 1'b0, 1'b0);

    // request raised at ph=3, dropped at ph=5: no window, no acknowledge
    idle_until(3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);

    // hblank held high from ph=0: borrowed window only when the feature is built in
    idle_until(0);
    dph = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (dtack_b == 1'b0) begin
        dph = phase;
        break;
      end
    end
    chk("hblank_done_phase", 8'(dph), hb_en ? 8'd4 : 8'd0);
    step(1'b0, 1'b0, 1'b0);

    // async reset during the first clock of a write window
    idle_until(5);
    step(1'b1, 1'b1, 1'b0);
    chk("grant_open", {7'b0, VBUS_b}, 8'd0);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    chk("held_vramwr", {7'b0, VRAMWR}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("rerelease_phase", {5'b0, phase}, 8'd1);

    // random traffic, including aborts, drops mid-window and cpu_we churn
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = ~r;
      if (acked && $urandom_range(0, 1) == 1) r = 1'b0;
      w = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      step(r, w, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
